// File: rtl/aibcr3_dcc_intp_therm_ramp_if.sv
// rtl/aibcr3_dcc_intp_therm_ramp_if.sv - control/status bundle for the DCC interpolator thermometer ramp
interface aibcr3_dcc_intp_therm_ramp_if #(
    parameter int GRAY_W = 3
);
    localparam int THERM_W = (1 << GRAY_W) - 1;

    logic [GRAY_W-1:0]  gray;
    logic               upd_en;
    logic               hold;
    logic               iSE;
    logic               iSI;
    logic               SOOUT;
    logic [THERM_W-1:0] sp;
    logic [THERM_W-1:0] sn;
    logic               busy;
    logic               done;
    logic               therm_err;

    modport master (
        output gray, upd_en, hold, iSE, iSI,
        input  SOOUT, sp, sn, busy, done, therm_err
    );

    modport slave (
        input  gray, upd_en, hold, iSE, iSI,
        output SOOUT, sp, sn, busy, done, therm_err
    );
endinterface

// File: rtl/aibcr3_dcc_intp_therm_ramp.sv
// rtl/aibcr3_dcc_intp_therm_ramp.sv - gray-to-thermometer interpolator code register with rate-limited ramp
module aibcr3_dcc_intp_therm_ramp #(
    parameter int GRAY_W   = 3,
    parameter int STEP_DIV = 4
) (
    input  logic                     CLKIN,
    input  logic                     PDb,
    aibcr3_dcc_intp_therm_ramp_if.slave bus
);
    localparam int THERM_W = (1 << GRAY_W) - 1;
    localparam int CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [GRAY_W-1:0]  tgt;
    logic [THERM_W-1:0] sp_q;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic               err_q;

    logic [THERM_W-1:0] tgt_therm;
    logic [THERM_W-1:0] edge_bits;
    logic [THERM_W-1:0] sp_step;
    logic [THERM_W-1:0] sp_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic               sp_valid;
    logic               at_tgt;
    logic               step_up;

    function automatic logic [GRAY_W-1:0] gray_to_bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Bit i is set when its index lies below the binary level, i.e. (1<<b)-1 without overflow.
    function automatic logic [THERM_W-1:0] bin_to_therm(input logic [GRAY_W-1:0] b);
        logic [THERM_W-1:0] t;
        for (int i = 0; i < THERM_W; i++) begin
            t[i] = (i < int'(b));
        end
        return t;
    endfunction

    // Target decodes from the registered setting only, so busy never sees gray combinationally.
    assign tgt_therm = bin_to_therm(gray_to_bin(tgt));
    assign edge_bits = sp_q & ~(sp_q << 1);
    assign sp_valid  = (edge_bits[THERM_W-1:1] == '0);
    assign at_tgt    = (sp_q == tgt_therm);
    assign step_up   = |(tgt_therm & ~sp_q);
    assign sp_step   = step_up ? {sp_q[THERM_W-2:0], 1'b1} : {1'b0, sp_q[THERM_W-1:1]};

    always_comb begin
        sp_nxt   = sp_q;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        err_nxt  = err_q;
        if (bus.iSE) begin
            sp_nxt = {sp_q[THERM_W-2:0], bus.iSI};
        end else if (!bus.hold) begin
            if (!sp_valid) begin
                sp_nxt  = tgt_therm;
                err_nxt = 1'b1;
                cnt_nxt = '0;
            end else if (at_tgt) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                sp_nxt   = sp_step;
                cnt_nxt  = '0;
                done_nxt = (sp_step == tgt_therm);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLKIN) begin
        if (!PDb) begin
            sp_q   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sp_q   <= sp_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    // A new setting captured on a step edge only steers the ramp from the following cycle.
    always_ff @(posedge CLKIN) begin
        if (!PDb) begin
            tgt <= '0;
        end else if (bus.upd_en && !bus.iSE) begin
            tgt <= bus.gray;
        end
    end

    assign bus.sp        = sp_q;
    assign bus.sn        = ~sp_q;
    assign bus.SOOUT     = sp_q[THERM_W-1];
    assign bus.busy      = !at_tgt;
    assign bus.done      = done_q;
    assign bus.therm_err = err_q;
endmodule

// File: tb/tb_aibcr3_dcc_intp_therm_ramp.sv
// tb/tb_aibcr3_dcc_intp_therm_ramp.sv - scoreboard bench for the thermometer ramp code register
module tb_aibcr3_dcc_intp_therm_ramp;
    localparam int GW  = 3;
    localparam int TW  = (1 << GW) - 1;
    localparam int DIV = 4;

    logic CLKIN = 1'b0;
    logic PDb   = 1'b0;
    always #5 CLKIN = ~CLKIN;

    aibcr3_dcc_intp_therm_ramp_if #(.GRAY_W(GW)) dut_if ();

    aibcr3_dcc_intp_therm_ramp #(.GRAY_W(GW), .STEP_DIV(DIV)) dut (
        .CLKIN (CLKIN),
        .PDb   (PDb),
        .bus   (dut_if)
    );

    typedef struct packed {
        logic [TW-1:0] sp;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   checks = 0;
    int   errors = 0;

    int   m_sp  = 0;
    int   m_tgt = 0;
    int   m_cnt = 0;
    bit   m_done = 1'b0;
    bit   m_err  = 1'b0;

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < GW; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int level_code(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic model(input int g, input bit u, input bit h, input bit se, input bit si, input bit rn);
        int tl;
        int lvl;
        tl = g2b(m_tgt);
        m_done = 1'b0;
        if (!rn) begin
            m_sp = 0; m_tgt = 0; m_cnt = 0; m_err = 1'b0;
        end else if (se) begin
            m_sp = ((m_sp << 1) | int'(si)) & level_code(TW);
        end else begin
            if (!h) begin
                if (m_sp != level_code($countones(m_sp))) begin
                    m_sp = level_code(tl); m_err = 1'b1; m_cnt = 0;
                end else if (m_sp == level_code(tl)) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DIV) begin
                        lvl = $countones(m_sp);
                        lvl = (tl > lvl) ? lvl + 1 : lvl - 1;
                        m_sp = level_code(lvl);
                        m_cnt = 0;
                        m_done = (lvl == tl);
                    end
                end
            end
            if (u) m_tgt = g;
        end
    endtask

    task automatic cyc(input int g, input bit u, input bit h, input bit se, input bit si, input bit rn);
        exp_t e;
        dut_if.gray   = GW'(g);
        dut_if.upd_en = u;
        dut_if.hold   = h;
        dut_if.iSE    = se;
        dut_if.iSI    = si;
        PDb           = rn;
        @(posedge CLKIN);
        model(g, u, h, se, si, rn);
        e.sp   = TW'(m_sp);
        e.busy = (m_sp != level_code(g2b(m_tgt)));
        e.done = m_done;
        e.err  = m_err;
        exp_q.push_back(e);
        @(negedge CLKIN);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_gray(input int g);
        cyc(g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge CLKIN) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.sp   = dut_if.sp;
            mon_a.busy = dut_if.busy;
            mon_a.done = dut_if.done;
            mon_a.err  = dut_if.therm_err;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL state t=%0t sp/busy/done/err actual=%b/%b/%b/%b required=%b/%b/%b/%b",
                         $time, mon_a.sp, mon_a.busy, mon_a.done, mon_a.err,
                         mon_e.sp, mon_e.busy, mon_e.done, mon_e.err);
            end
            checks++;
            if ({dut_if.sn, dut_if.SOOUT} !== {~mon_e.sp, mon_e.sp[TW-1]}) begin
                errors++;
                $display("FAIL sn_soout t=%0t actual=%b/%b required=%b/%b",
                         $time, dut_if.sn, dut_if.SOOUT, ~mon_e.sp, mon_e.sp[TW-1]);
            end
        end
    end

    initial begin
        int guard;
        dut_if.gray = '0; dut_if.upd_en = 1'b0; dut_if.hold = 1'b0;
        dut_if.iSE = 1'b0; dut_if.iSI = 1'b0;

        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        set_gray(3'b100);
        idle(32);

        for (int g = 0; g < (1 << GW); g++) begin
            set_gray(g);
            idle(TW * DIV + 3);
        end

        set_gray(0);
        idle(TW * DIV + 3);
        set_gray(3'b100);
        guard = 0;
        while (m_sp != 7'b0001111 && guard < 100) begin
            idle(1);
            guard++;
        end
        set_gray(3'b001);
        idle(20);

        set_gray(0);
        idle(TW * DIV + 3);
        set_gray(3'b100);
        idle(9);
        for (int i = 0; i < 10; i++) cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(TW * DIV);

        set_gray(3'b110);
        idle(6);
        set_gray(0);
        for (int i = 0; i < TW; i++) begin
            automatic logic [6:0] pat = 7'b0101010;
            cyc(0, 1'b0, 1'b0, 1'b1, pat[TW-1-i], 1'b1);
        end
        idle(4);

        set_gray(3'b101);
        idle(10);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_gray(3'b100);
        idle(TW * DIV + 2);
        set_gray(3'b011);
        idle(4);
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(12);

        for (int i = 0; i < 600; i++) begin
            cyc(int'($urandom_range(0, (1 << GW) - 1)),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 29) == 0,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 99) != 0);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge CLKIN);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
